// File: rtl/onehot_strobe_decoder_pkg.sv
// onehot_strobe_decoder_pkg: shared defaults and FSM state encoding
package onehot_strobe_decoder_pkg;
  localparam int IDX_W_DEF = 4;
  localparam int LEN_W_DEF = 4;
  localparam int DEPTH_DEF = 4;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRIVE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;
endpackage

// File: rtl/onehot_strobe_decoder_if.sv
// onehot_strobe_decoder_if: command port and strobe outputs of the decoder
interface onehot_strobe_decoder_if
  import onehot_strobe_decoder_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int DEPTH = DEPTH_DEF
);
  logic                       in_valid;
  logic                       in_ready;
  logic [IDX_W-1:0]           in_idx;
  logic [LEN_W-1:0]           in_len;
  logic [(1<<IDX_W)-1:0]      out_onehot;
  logic                       out_valid;
  logic                       busy;
  logic [$clog2(DEPTH):0]     fifo_count;
  modport master (
    output in_valid, in_idx, in_len,
    input  in_ready, out_onehot, out_valid, busy, fifo_count
  );
  modport slave (
    input  in_valid, in_idx, in_len,
    output in_ready, out_onehot, out_valid, busy, fifo_count
  );
endinterface

// File: rtl/onehot_strobe_decoder_sync_fifo.sv
// sync_fifo: circular command buffer with occupancy count
module sync_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  assign full    = count == CW'(DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];
  // pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(do_push);
      rd_ptr <= rd_ptr + PW'(do_pop);
      count  <= count + CW'(do_push) - CW'(do_pop);
    end
  end
  // storage needs no reset; only entries below count are ever read
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/onehot_strobe_decoder.sv
// onehot_strobe_decoder: turns queued (index, length) commands into timed one-hot strobes
module onehot_strobe_decoder
  import onehot_strobe_decoder_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEF,
  parameter int LEN_W = LEN_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input logic CLK,
  input logic RST_N,
  onehot_strobe_decoder_if.slave bus
);
  localparam int W  = 1 << IDX_W;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [IDX_W+LEN_W-1:0] head;
  logic [IDX_W-1:0]       h_idx;
  logic [LEN_W-1:0]       h_len;
  logic [LEN_W-1:0]       rem;
  logic [1:0]             state;
  logic [W-1:0]           onehot;
  logic [CW-1:0]          count;
  logic                   full, empty, pop;
  assign {h_idx, h_len} = head;
  assign pop = !empty && (state == ST_IDLE || state == ST_GAP);
  sync_fifo #(.W(IDX_W + LEN_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (CLK),
    .rst_n (RST_N),
    .push  (bus.in_valid),
    .pop   (pop),
    .wdata ({bus.in_idx, bus.in_len}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );
  // strobe sequencer: load on pop, count down while driving, one forced idle cycle after
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      onehot <= '0;
      rem    <= '0;
    end else if (pop) begin
      state  <= ST_DRIVE;
      onehot <= W'(1) << h_idx;
      rem    <= (h_len == '0) ? '0 : h_len - 1'b1;
    end else if (state == ST_DRIVE) begin
      state  <= (rem == '0) ? ST_GAP : ST_DRIVE;
      onehot <= (rem == '0) ? '0 : onehot;
      rem    <= (rem == '0) ? rem : rem - 1'b1;
    end else begin
      state  <= ST_IDLE;
      onehot <= '0;
    end
  end
  assign bus.in_ready   = !full;
  assign bus.out_onehot = onehot;
  assign bus.out_valid  = |onehot;
  assign bus.busy       = (state != ST_IDLE) || !empty;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_onehot_strobe_decoder.sv
// tb_onehot_strobe_decoder: directed and random stimulus against an output-stream reference model
module tb_onehot_strobe_decoder;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  int q_idx[$];
  int q_len[$];
  logic [15:0] stream[$];
  logic [15:0] cur = '0;
  bit active = 0;
  bit accepted = 0;
  onehot_strobe_decoder_if #(.IDX_W(4), .LEN_W(4), .DEPTH(DEPTH)) bus ();
  onehot_strobe_decoder #(.IDX_W(4), .LEN_W(4), .DEPTH(DEPTH)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus.slave)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    q_idx.delete();
    q_len.delete();
    stream.delete();
    cur = '0;
    active = 0;
    accepted = 0;
  endtask
  // a popped command expands into its whole future output sequence: L strobe words then one zero
  task automatic model_edge();
    bit can_pop;
    int idx, len;
    can_pop = (cur == 0) && (q_idx.size() > 0);
    accepted = (bus.in_valid === 1'b1) && (q_idx.size() < DEPTH);
    if (can_pop) begin
      idx = q_idx.pop_front();
      len = q_len.pop_front();
      if (len == 0) len = 1;
      for (int i = 0; i < len; i++) stream.push_back(16'(1 << idx));
      stream.push_back(16'h0000);
    end
    if (accepted) begin
      q_idx.push_back(int'(bus.in_idx));
      q_len.push_back(int'(bus.in_len));
    end
    if (stream.size() > 0) begin
      cur = stream.pop_front();
      active = 1;
    end else begin
      cur = '0;
      active = 0;
    end
  endtask
  task automatic check_all();
    chk("out_onehot", 32'(bus.out_onehot), 32'(cur));
    chk("out_valid", 32'(bus.out_valid), 32'(cur != 0));
    chk("busy", 32'(bus.busy), 32'(active || q_idx.size() > 0));
    chk("in_ready", 32'(bus.in_ready), 32'(q_idx.size() < DEPTH));
    chk("fifo_count", 32'(bus.fifo_count), 32'(q_idx.size()));
    chk("onehot0", 32'($onehot0(bus.out_onehot)), 32'd1);
  endtask
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge();
    #1;
    check_all();
  endtask
  task automatic push(input int idx, input int len);
    bus.in_idx = 4'(idx);
    bus.in_len = 4'(len);
    bus.in_valid = 1'b1;
    accepted = 0;
    for (int i = 0; i < 200; i++) begin
      cycle();
      if (accepted) break;
    end
    chk("push_accepted", 32'(accepted), 32'd1);
    bus.in_valid = 1'b0;
    bus.in_idx = 4'($urandom);
    bus.in_len = 4'($urandom);
  endtask
  task automatic idle(input int n);
    repeat (n) cycle();
  endtask
  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_idx = '0;
    bus.in_len = '0;
    #1;
    model_reset();
    check_all();
    idle(2);
    @(negedge clk) rst_n = 1'b1;
    cycle();
    chk("ready_after_release", 32'(bus.in_ready), 32'd1);
    push(0, 1);
    chk("lat_edge_k", 32'(bus.out_onehot), 32'h0);
    cycle();
    chk("lat_edge_k1", 32'(bus.out_onehot), 32'h0001);
    cycle();
    chk("single_cycle_end", 32'(bus.out_onehot), 32'h0);
    idle(3);
    chk("busy_idle", 32'(bus.busy), 32'd0);
    push(15, 0);
    idle(4);
    push(3, 15);
    idle(20);
    push(5, 2);
    push(5, 2);
    push(9, 2);
    push(2, 2);
    push(11, 2);
    idle(30);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 12; i++) push($urandom_range(0, 15), $urandom_range(0, 3));
    idle(60);
    for (int i = 0; i < 300; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_idx = 4'($urandom);
      bus.in_len = 4'($urandom_range(0, 4));
      cycle();
    end
    bus.in_valid = 1'b0;
    idle(80);
    push(7, 10);
    push(1, 2);
    push(2, 2);
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      if (bus.out_onehot == 16'h0080) n++;
      if (n < 4) cycle();
    end
    chk("mid_strobe_reached", 32'(n), 32'd4);
    chk("queued_before_reset", 32'(bus.fifo_count), 32'd2);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_out", 32'(bus.out_onehot), 32'h0);
    chk("async_valid", 32'(bus.out_valid), 32'd0);
    chk("async_busy", 32'(bus.busy), 32'd0);
    chk("async_count", 32'(bus.fifo_count), 32'd0);
    chk("async_ready", 32'(bus.in_ready), 32'd1);
    idle(3);
    @(negedge clk) rst_n = 1'b1;
    idle(30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
